// File: rtl/throw_turn_sched.sv
// Two-player turn scheduler for the shared projectile engine.
// Handles force charging, flight supervision, damage, and turn handover.
module throw_turn_sched #(
    parameter int unsigned FORCE_TICK     = 65000,
    parameter int unsigned FORCE_MAX      = 1000,
    parameter int unsigned HP_INIT        = 5,
    parameter int unsigned DAMAGE         = 1,
    parameter int unsigned FLIGHT_TIMEOUT = 2**26,
    parameter int unsigned SETTLE_CYC     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       fire_p0,
    input  logic       fire_p1,
    input  logic       throw_done,
    input  logic       hit,
    output logic       throw_en,
    output logic [9:0] throw_force,
    output logic       active,
    output logic       charging,
    output logic [3:0] hp0,
    output logic [3:0] hp1,
    output logic       game_over,
    output logic       winner
);

    localparam int TW = (FORCE_TICK > 1) ? $clog2(FORCE_TICK) : 1;
    localparam int FW = (FLIGHT_TIMEOUT > 1) ? $clog2(FLIGHT_TIMEOUT) : 1;
    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [TW-1:0] TICK_LAST   = TW'(FORCE_TICK - 1);
    localparam logic [FW-1:0] FLIGHT_LAST = FW'(FLIGHT_TIMEOUT - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [9:0]    FMAX        = 10'(FORCE_MAX);
    localparam logic [3:0]    HP0         = 4'(HP_INIT);
    localparam logic [3:0]    DMG         = 4'(DAMAGE);

    typedef enum logic [2:0] {
        S_IDLE, S_AIM, S_CHARGE, S_FLIGHT, S_SETTLE, S_OVER
    } state_t;

    state_t        state_q, state_d;
    logic [9:0]    force_q, force_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [FW-1:0] flight_q, flight_d;
    logic [SW-1:0] settle_q, settle_d;
    logic          hit_seen_q, hit_seen_d;
    logic          active_q, active_d;
    logic [3:0]    hp0_q, hp0_d;
    logic [3:0]    hp1_q, hp1_d;
    logic          winner_q, winner_d;
    logic          en_q, chg_q, over_q;

    logic          fire_act;
    logic [3:0]    opp_hp;

    function automatic logic [3:0] dec(input logic [3:0] v);
        return (v >= DMG) ? v - DMG : 4'd0;
    endfunction

    assign fire_act = active_q ? fire_p1 : fire_p0;
    assign opp_hp   = active_q ? hp0_q : hp1_q;

    always_comb begin
        state_d    = state_q;
        force_d    = force_q;
        tick_d     = tick_q;
        flight_d   = flight_q;
        settle_d   = settle_q;
        hit_seen_d = hit_seen_q;
        active_d   = active_q;
        hp0_d      = hp0_q;
        hp1_d      = hp1_q;
        winner_d   = winner_q;
        unique case (state_q)
            S_IDLE, S_OVER: begin
                if (start) begin
                    state_d  = S_AIM;
                    hp0_d    = HP0;
                    hp1_d    = HP0;
                    active_d = 1'b0;
                    force_d  = '0;
                end
            end
            S_AIM: begin
                if (fire_act) begin
                    state_d = S_CHARGE;
                    force_d = '0;
                    tick_d  = '0;
                end
            end
            S_CHARGE: begin
                if (!fire_act) begin
                    if (force_q == '0) begin
                        state_d = S_AIM;
                    end else begin
                        state_d    = S_FLIGHT;
                        flight_d   = '0;
                        hit_seen_d = 1'b0;
                    end
                end else if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    if (force_q < FMAX) force_d = force_q + 10'd1;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            S_FLIGHT: begin
                flight_d = flight_q + 1'b1;
                // Only the first hit of a flight deals damage.
                if (hit && !hit_seen_q) begin
                    hit_seen_d = 1'b1;
                    if (active_q) hp0_d = dec(hp0_q);
                    else          hp1_d = dec(hp1_q);
                end
                if (throw_done || flight_q == FLIGHT_LAST) begin
                    state_d  = S_SETTLE;
                    settle_d = '0;
                end
            end
            S_SETTLE: begin
                settle_d = settle_q + 1'b1;
                if (settle_q == SETTLE_LAST) begin
                    if (opp_hp == '0) begin
                        state_d  = S_OVER;
                        winner_d = active_q;
                    end else begin
                        state_d  = S_AIM;
                        active_d = ~active_q;
                        force_d  = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            force_q    <= '0;
            tick_q     <= '0;
            flight_q   <= '0;
            settle_q   <= '0;
            hit_seen_q <= 1'b0;
            active_q   <= 1'b0;
            hp0_q      <= HP0;
            hp1_q      <= HP0;
            winner_q   <= 1'b0;
            en_q       <= 1'b0;
            chg_q      <= 1'b0;
            over_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            force_q    <= force_d;
            tick_q     <= tick_d;
            flight_q   <= flight_d;
            settle_q   <= settle_d;
            hit_seen_q <= hit_seen_d;
            active_q   <= active_d;
            hp0_q      <= hp0_d;
            hp1_q      <= hp1_d;
            winner_q   <= winner_d;
            en_q       <= (state_d == S_FLIGHT);
            chg_q      <= (state_d == S_CHARGE);
            over_q     <= (state_d == S_OVER);
        end
    end

    assign throw_en    = en_q;
    assign throw_force = force_q;
    assign active      = active_q;
    assign charging    = chg_q;
    assign hp0         = hp0_q;
    assign hp1         = hp1_q;
    assign game_over   = over_q;
    assign winner      = winner_q;

endmodule

// File: tb/tb_throw_turn_sched.sv
// Directed scoreboard bench for throw_turn_sched.
// Small parameters keep charge, flight and settle phases short.
module tb_throw_turn_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       fire_p0 = 1'b0;
    logic       fire_p1 = 1'b0;
    logic       throw_done = 1'b0;
    logic       hit = 1'b0;
    logic       throw_en;
    logic [9:0] throw_force;
    logic       active;
    logic       charging;
    logic [3:0] hp0;
    logic [3:0] hp1;
    logic       game_over;
    logic       winner;

    int vectors = 0;
    int errors = 0;
    string tag_q[$];
    logic [31:0] exp_q[$];
    int m_hp0 = 2;
    int m_hp1 = 2;
    logic m_act = 1'b0;

    throw_turn_sched #(
        .FORCE_TICK(4), .FORCE_MAX(10), .HP_INIT(2),
        .DAMAGE(1), .FLIGHT_TIMEOUT(50), .SETTLE_CYC(3)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .fire_p0(fire_p0), .fire_p1(fire_p1),
        .throw_done(throw_done), .hit(hit),
        .throw_en(throw_en), .throw_force(throw_force),
        .active(active), .charging(charging),
        .hp0(hp0), .hp1(hp1),
        .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string t, input logic [31:0] e);
        tag_q.push_back(t);
        exp_q.push_back(e);
    endtask

    task automatic pop(input logic [31:0] o);
        string t;
        logic [31:0] e;
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        vectors++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", t, o, e);
        end
    endtask

    task automatic chk(input string t, input logic [31:0] o,
                       input logic [31:0] e);
        push(t, e);
        pop(o);
    endtask

    task automatic check_reset();
        chk("rst_en", 32'(throw_en), 0);
        chk("rst_force", 32'(throw_force), 0);
        chk("rst_active", 32'(active), 0);
        chk("rst_charging", 32'(charging), 0);
        chk("rst_hp0", 32'(hp0), 2);
        chk("rst_hp1", 32'(hp1), 2);
        chk("rst_over", 32'(game_over), 0);
        chk("rst_winner", 32'(winner), 0);
    endtask

    task automatic launch(input logic p, input int hold);
        int f;
        f = (hold - 1) / 4;
        if (f > 10) f = 10;
        if (p) fire_p1 = 1'b1;
        else   fire_p0 = 1'b1;
        repeat (hold) tick();
        chk("charging", 32'(charging), 1);
        chk("pre_en", 32'(throw_en), 0);
        if (p) fire_p1 = 1'b0;
        else   fire_p0 = 1'b0;
        push("force", 32'(f));
        tick();
        pop(32'(throw_force));
        chk("en_rise", 32'(throw_en), 1);
    endtask

    task automatic settle_and_swap();
        logic old;
        old = m_act;
        for (int i = 0; i < 3; i++) begin
            chk("settle_en", 32'(throw_en), 0);
            chk("settle_act", 32'(active), 32'(old));
            tick();
        end
        m_act = ~old;
        chk("act_swap", 32'(active), 32'(m_act));
        chk("aim_force", 32'(throw_force), 0);
    endtask

    initial begin
        int n;
        logic rose;
        repeat (3) tick();
        check_reset();
        rst = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;

        // p0: 13 cycles of charge gives force 3
        launch(1'b0, 13);
        repeat (4) tick();
        chk("force_frozen", 32'(throw_force), 3);
        chk("en_held", 32'(throw_en), 1);
        throw_done = 1'b1;
        tick();
        throw_done = 1'b0;
        settle_and_swap();

        // p1: long hold saturates, p0 fire ignored, two hits
        fire_p0 = 1'b1;
        launch(1'b1, 100);
        fire_p0 = 1'b0;
        chk("sat_force", 32'(throw_force), 10);
        tick();
        hit = 1'b1;
        tick();
        hit = 1'b0;
        m_hp0 = m_hp0 - 1;
        chk("hit1_hp0", 32'(hp0), 32'(m_hp0));
        tick();
        hit = 1'b1;
        tick();
        hit = 1'b0;
        tick();
        throw_done = 1'b1;
        tick();
        throw_done = 1'b0;
        chk("hit2_hp0", 32'(hp0), 32'(m_hp0));
        chk("hp1_same", 32'(hp1), 32'(m_hp1));
        settle_and_swap();

        // p0: hit while aiming, then a tap that must not launch
        hit = 1'b1;
        tick();
        hit = 1'b0;
        chk("aim_hit_hp1", 32'(hp1), 32'(m_hp1));
        chk("aim_hit_hp0", 32'(hp0), 32'(m_hp0));
        fire_p0 = 1'b1;
        tick();
        tick();
        fire_p0 = 1'b0;
        rose = 1'b0;
        repeat (6) begin
            tick();
            if (throw_en) rose = 1'b1;
        end
        chk("tap_no_en", 32'(rose), 0);
        chk("tap_active", 32'(active), 0);
        chk("tap_charging", 32'(charging), 0);

        // p0: flight timeout with fire_p1 toggling
        launch(1'b0, 5);
        n = 1;
        hit = 1'b1;
        while (throw_en && n < 200) begin
            fire_p1 = ~fire_p1;
            tick();
            hit = 1'b0;
            if (throw_en) n++;
        end
        fire_p1 = 1'b0;
        chk("timeout_len", 32'(n), 50);
        m_hp1 = m_hp1 - 1;
        chk("to_hp1", 32'(hp1), 32'(m_hp1));
        settle_and_swap();

        // p1: clean miss
        launch(1'b1, 6);
        throw_done = 1'b1;
        tick();
        throw_done = 1'b0;
        chk("miss_hp0", 32'(hp0), 32'(m_hp0));
        settle_and_swap();

        // p0: hit and done together finishes the game
        launch(1'b0, 5);
        hit = 1'b1;
        throw_done = 1'b1;
        tick();
        hit = 1'b0;
        throw_done = 1'b0;
        chk("kill_hp1", 32'(hp1), 0);
        for (int i = 0; i < 3; i++) begin
            chk("ko_settle_en", 32'(throw_en), 0);
            chk("ko_not_over", 32'(game_over), 0);
            tick();
        end
        chk("over", 32'(game_over), 1);
        chk("winner", 32'(winner), 0);
        fire_p0 = 1'b1;
        hit = 1'b1;
        repeat (5) tick();
        fire_p0 = 1'b0;
        hit = 1'b0;
        chk("over_hold", 32'(game_over), 1);
        chk("over_hp1", 32'(hp1), 0);
        chk("over_hp0", 32'(hp0), 32'(m_hp0));
        chk("over_en", 32'(throw_en), 0);
        chk("over_chg", 32'(charging), 0);
        chk("over_winner", 32'(winner), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_over", 32'(game_over), 0);
        chk("restart_hp0", 32'(hp0), 2);
        chk("restart_hp1", 32'(hp1), 2);
        chk("restart_act", 32'(active), 0);

        // async reset in the middle of a flight
        launch(1'b0, 9);
        tick();
        #2;
        rst = 1'b1;
        #1;
        check_reset();
        tick();
        rst = 1'b0;
        tick();
        check_reset();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
